pulse_hold_gate: RTL and testbench

PULSE_HOLD_GATE -- requirements
Module: pulse_hold_gate

---
 rtl/pulse_hold_gate.sv | 75 +++++++
 tb/tb_pulse_hold_gate.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pulse_hold_gate.sv
// pulse_hold_gate: per-channel data gate that forces a channel to IDLE_VALUE
// for HOLD_CYCLES cycles after each enable pulse.
//
// Ports:
//   clk        - single clock; all state updates on its rising edge
//   rst        - synchronous active-high reset; loads every hold counter
//   enable     - [CHANNELS] per-channel hold trigger (restarts the count)
//   release_i  - [CHANNELS] per-channel early cancel of an active hold
//   data       - [CHANNELS*WIDTH] input data, channel c at [c*WIDTH +: WIDTH]
//   data_o     - [CHANNELS*WIDTH] gated data, same packing as data
//   held_o     - [CHANNELS] bit c high while channel c is held
//   any_held_o - OR of held_o
module pulse_hold_gate #(
   parameter int               WIDTH       = 8,
   parameter int               CHANNELS    = 1,
   parameter int               HOLD_CYCLES = 1,
   parameter logic [WIDTH-1:0] IDLE_VALUE  = {WIDTH{1'b0}}
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CHANNELS-1:0]       enable,
   input  logic [CHANNELS-1:0]       release_i,
   input  logic [CHANNELS*WIDTH-1:0] data,
   output logic [CHANNELS*WIDTH-1:0] data_o,
   output logic [CHANNELS-1:0]       held_o,
   output logic                      any_held_o
);

   localparam int CW = $clog2(HOLD_CYCLES + 1);
   localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES);
   localparam logic [CW-1:0] ONE     = CW'(1);

   logic [CW-1:0] cnt_q [CHANNELS];
   logic [CW-1:0] cnt_d [CHANNELS];

   // Trigger beats cancel; a zero counter is absorbing, so no wrap.
   always_comb begin
      for (int c = 0; c < CHANNELS; c++) begin
         cnt_d[c] = cnt_q[c];
         if (enable[c]) begin
            cnt_d[c] = HOLD_LD;
         end else if (release_i[c]) begin
            cnt_d[c] = '0;
         end else if (cnt_q[c] != '0) begin
            cnt_d[c] = cnt_q[c] - ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int c = 0; c < CHANNELS; c++) begin
         if (rst) begin
            cnt_q[c] <= HOLD_LD;
         end else begin
            cnt_q[c] <= cnt_d[c];
         end
      end
   end

   // Outputs decode registered state only; data path has zero latency.
   always_comb begin
      data_o = '0;
      held_o = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         held_o[c] = (cnt_q[c] != '0);
         if (held_o[c]) begin
            data_o[c*WIDTH +: WIDTH] = IDLE_VALUE;
         end else begin
            data_o[c*WIDTH +: WIDTH] = data[c*WIDTH +: WIDTH];
         end
      end
      any_held_o = |held_o;
   end

endmodule

// File: tb/tb_pulse_hold_gate.sv
// tb_pulse_hold_gate: directed bench for pulse_hold_gate with
// WIDTH=8, CHANNELS=2, HOLD_CYCLES=3, IDLE_VALUE=8'h00.
module tb_pulse_hold_gate;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  enable;
   logic [1:0]  release_i;
   logic [15:0] data;
   logic [15:0] data_o;
   logic [1:0]  held_o;
   logic        any_held_o;

   int tests = 0;
   int fails = 0;

   pulse_hold_gate #(
      .WIDTH       (8),
      .CHANNELS    (2),
      .HOLD_CYCLES (3),
      .IDLE_VALUE  (8'h00)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .release_i  (release_i),
      .data       (data),
      .data_o     (data_o),
      .held_o     (held_o),
      .any_held_o (any_held_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [15:0] exp_d,
                          input logic [1:0] exp_h);
      chk({tag, ".data"}, 32'(data_o), 32'(exp_d));
      chk({tag, ".held"}, 32'(held_o), 32'(exp_h));
      chk({tag, ".any"}, 32'(any_held_o), 32'(|exp_h));
   endtask

   initial begin
      rst       = 1'b1;
      enable    = 2'b00;
      release_i = 2'b00;
      data      = 16'h3CA5;

      // reset release
      tick();
      chk_out("rst_in", 16'h0000, 2'b11);
      enable    = 2'b11;
      release_i = 2'b11;
      tick();
      chk_out("rst_ovr", 16'h0000, 2'b11);
      rst       = 1'b0;
      enable    = 2'b00;
      release_i = 2'b00;
      #1;
      chk_out("rel_c1", 16'h0000, 2'b11);
      tick();
      chk_out("rel_c2", 16'h0000, 2'b11);
      tick();
      chk_out("rel_c3", 16'h0000, 2'b11);
      tick();
      chk_out("rel_pass", 16'h3CA5, 2'b00);

      // zero-latency pass-through
      data = 16'h1234;
      #1;
      chk_out("comb", 16'h1234, 2'b00);
      data = 16'h3CA5;
      #1;

      // single trigger on channel 0
      enable = 2'b01;
      tick();
      enable = 2'b00;
      chk_out("one_t1", 16'h3C00, 2'b01);
      tick();
      chk_out("one_t2", 16'h3C00, 2'b01);
      tick();
      chk_out("one_t3", 16'h3C00, 2'b01);
      tick();
      chk_out("one_pass", 16'h3CA5, 2'b00);

      // retrigger on channel 0
      enable = 2'b01;
      tick();
      enable = 2'b00;
      chk_out("rt_1", 16'h3C00, 2'b01);
      tick();
      enable = 2'b01;
      chk_out("rt_2", 16'h3C00, 2'b01);
      tick();
      enable = 2'b00;
      chk_out("rt_3", 16'h3C00, 2'b01);
      tick();
      chk_out("rt_4", 16'h3C00, 2'b01);
      tick();
      chk_out("rt_5", 16'h3C00, 2'b01);
      tick();
      chk_out("rt_pass", 16'h3CA5, 2'b00);

      // enable and cancel on channel 1
      enable = 2'b10;
      tick();
      enable    = 2'b00;
      release_i = 2'b10;
      chk_out("rls_held", 16'h00A5, 2'b10);
      tick();
      release_i = 2'b00;
      chk_out("rls_pass", 16'h3CA5, 2'b00);

      // enable wins over cancel
      enable    = 2'b10;
      release_i = 2'b10;
      tick();
      enable    = 2'b00;
      release_i = 2'b00;
      chk_out("col_1", 16'h00A5, 2'b10);
      tick();
      chk_out("col_2", 16'h00A5, 2'b10);
      tick();
      chk_out("col_3", 16'h00A5, 2'b10);
      tick();
      chk_out("col_pass", 16'h3CA5, 2'b00);

      // cancel on an idle counter does nothing
      release_i = 2'b11;
      tick();
      release_i = 2'b00;
      chk_out("rls_idle", 16'h3CA5, 2'b00);

      // steady enable keeps channel 1 idle; channel 0 independent
      enable = 2'b10;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk_out("steady", 16'h00A5, 2'b10);
      end
      enable = 2'b00;
      tick();
      chk_out("steady_e1", 16'h00A5, 2'b10);
      tick();
      tick();
      chk_out("steady_end", 16'h3CA5, 2'b00);

      // reset mid-hold reloads full count on both channels
      enable = 2'b01;
      tick();
      enable = 2'b00;
      tick();
      chk_out("mid_pre", 16'h3C00, 2'b01);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_out("mid_1", 16'h0000, 2'b11);
      tick();
      chk_out("mid_2", 16'h0000, 2'b11);
      tick();
      chk_out("mid_3", 16'h0000, 2'b11);
      tick();
      chk_out("mid_pass", 16'h3CA5, 2'b00);

      // cancel after reset shortens the window, per channel
      rst = 1'b1;
      tick();
      rst       = 1'b0;
      release_i = 2'b01;
      tick();
      release_i = 2'b00;
      chk_out("rst_rls", 16'h00A5, 2'b10);
      tick();
      chk_out("rst_rls2", 16'h00A5, 2'b10);
      tick();
      chk_out("rst_rls3", 16'h3CA5, 2'b00);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
